priority_encoder4_2: RTL



---
 rtl/priority_encoder4_2.sv | 96 +++++++++
 1 files changed

// File: rtl/priority_encoder4_2.sv
// Registered request encoder: sticky pending requests, one encoded index issued at a time under valid/ack.
// Optional ROUND_ROBIN_EN rotates priority from the last issued index; default is fixed priority (bit 0 highest).
module priority_encoder4_2 #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] idx,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         multi
);

    logic [N-1:0] newreq;
    logic         load;
    logic         any_pending;
    logic [W-1:0] sel;
    logic [N-1:0] sel_onehot;

    always_comb begin
        newreq      = en ? req : '0;
        load        = !valid || ack;
        any_pending = |pending;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi       = |(pending & (pending - N'(1)));
        sel_onehot  = N'(1) << sel;
    end

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] last;

    // Search starts just above the last issued line and wraps.
    always_comb begin
        logic         found;
        int           pos;
        logic [W-1:0] pos_w;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        sel   = '0;
        found = 1'b0;
        pos   = 0;
        pos_w = '0;
        for (int k = 0; k < N; k++) begin
            pos   = (int'(last) + 1 + k) % N;
            pos_w = W'(pos);
            if (!found && pending[pos_w]) begin
                sel   = pos_w;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= W'(N - 1);
        end else if (load && any_pending) begin
            last <= sel;
        end
    end
`else
    // Scanning downward lets the lowest set bit win.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[W'(i)]) begin
                sel = W'(i);
            end
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            idx     <= '0;
            pending <= '0;
        end else if (load) begin
            if (any_pending) begin
                valid   <= 1'b1;
                idx     <= sel;
                // A same-edge request on the issued line re-sets it as a fresh request.
                pending <= (pending & ~sel_onehot) | newreq;
            end else begin
                valid   <= 1'b0;
                pending <= newreq;
            end
        end else begin
            pending <= pending | newreq;
        end
    end

endmodule
